// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALUOp encodings, FSM states and decode bundle shared by the multicycle controller
package ctrl_pkg;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_RI  = 2'b10;
  localparam logic [1:0] ALU_JL  = 2'b11;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;
  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       lw;
    logic       sw;
    logic       br;
    logic       jal;
  } dec_t;
  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI};
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: latched opcode -> per-instruction control bits
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);
  always_comb begin
    dec.lw = opcode == OP_LW;
    dec.sw = opcode == OP_SW;
    dec.br = opcode == OP_BR;
    dec.jal = opcode == OP_JAL;
    dec.alu_src = opcode inside {OP_LW, OP_SW, OP_I, OP_LUI};
    dec.alu_op = (opcode inside {OP_LW, OP_SW}) ? ALU_MEM :
                 (opcode == OP_BR) ? ALU_BR :
                 (opcode inside {OP_R, OP_I}) ? ALU_RI :
                 (opcode inside {OP_JAL, OP_LUI}) ? ALU_JL : ALU_MEM;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM with memory timeout and retire counter
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          Opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic [1:0]          ALUOp,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                illegal,
  output logic                mem_fault,
  output logic [RETIRE_W-1:0] retired
);
  state_t state, next;
  logic [6:0] opcode_q;
  logic [7:0] wait_cnt;
  logic retire, act;
  dec_t dec;
  ctrl_decode u_dec (.opcode(opcode_q), .dec(dec));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      opcode_q <= '0;
      wait_cnt <= '0;
      retired <= '0;
    end else begin
      state <= next;
      if (state == DECODE) opcode_q <= Opcode;
      wait_cnt <= (state == MEMORY && !mem_ready) ? wait_cnt + 8'd1 : '0;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end
  always_comb begin
    next = state;
    retire = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    illegal = 1'b0;
    mem_fault = 1'b0;
    RegWrite = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    Branch = 1'b0;
    act = state inside {EXECUTE, MEMORY, WRITEBACK};
    ALUSrc = act & dec.alu_src;
    ALUOp = act ? dec.alu_op : 2'b00;
    case (state)
      FETCH: begin
        IRWrite = instr_valid;
        next = instr_valid ? DECODE : FETCH;
      end
      DECODE: begin
        illegal = !op_legal(Opcode);
        PCWrite = illegal;
        next = illegal ? FETCH : EXECUTE;
      end
      EXECUTE: begin
        Branch = dec.br;
        PCWrite = dec.br;
        retire = dec.br;
        next = dec.br ? FETCH : (dec.lw | dec.sw) ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        MemRead = dec.lw;
        MemWrite = dec.sw;
        mem_fault = !mem_ready && wait_cnt == 8'(MEM_TIMEOUT);
        retire = mem_ready & dec.sw;
        PCWrite = mem_fault | retire;
        next = (mem_fault || (mem_ready && dec.sw)) ? FETCH : mem_ready ? WRITEBACK : MEMORY;
      end
      WRITEBACK: begin
        RegWrite = 1'b1;
        PCWrite = 1'b1;
        MemtoReg = dec.lw;
        Branch = dec.jal;
        retire = 1'b1;
        next = FETCH;
      end
      default: next = FETCH;
    endcase
    if (reset) begin
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      illegal = 1'b0;
      mem_fault = 1'b0;
      RegWrite = 1'b0;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      Branch = 1'b0;
      ALUSrc = 1'b0;
      ALUOp = 2'b00;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction expected output traces built from latency rules, random inputs on don't-care cycles
module tb_multicycle_controller;
  localparam int T = 4;
  localparam int RW_W = 2;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111;
  localparam logic [11:0] IRW = 12'h800, PCW = 12'h400, ILL = 12'h200, FLT = 12'h100;
  localparam logic [11:0] M2R = 12'h040, RWR = 12'h020, MRD = 12'h010, MWR = 12'h008, BRB = 12'h004;
  logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite, illegal, mem_fault;
  logic [1:0] ALUOp;
  logic [RW_W-1:0] retired, exp_ret;
  logic [11:0] outs;
  int n_chk = 0, n_fail = 0;
  multicycle_controller #(.MEM_TIMEOUT(T), .RETIRE_W(RW_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .instr_valid(instr_valid), .mem_ready(mem_ready),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUOp(ALUOp), .IRWrite(IRWrite), .PCWrite(PCWrite), .illegal(illegal),
    .mem_fault(mem_fault), .retired(retired)
  );
  always #5 clk = ~clk;
  assign outs = {IRWrite, PCWrite, illegal, mem_fault, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};
  // w = wait cycles before mem_ready; w > T means memory never answers
  task automatic issue(input logic [6:0] op, input int w, input int dly, input string name);
    logic [11:0] tr[$];
    logic [11:0] a, mb, want;
    logic [1:0] aop;
    logic src;
    bit legal, mem, ret;
    legal = op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI};
    mem = op == OP_LW || op == OP_SW;
    src = op inside {OP_LW, OP_SW, OP_I, OP_LUI};
    aop = mem ? 2'b00 : op == OP_BR ? 2'b01 : (op == OP_R || op == OP_I) ? 2'b10 : 2'b11;
    a = {4'b0, src, 5'b0, aop};
    mb = op == OP_LW ? MRD : MWR;
    ret = 1;
    tr.push_back(IRW);
    if (!legal) begin
      tr.push_back(ILL | PCW);
      ret = 0;
    end else begin
      tr.push_back(12'd0);
      if (op == OP_BR) tr.push_back(a | BRB | PCW);
      else if (mem) begin
        tr.push_back(a);
        for (int k = 0; k < (w > T ? T : w); k++) tr.push_back(a | mb);
        if (w > T) begin
          tr.push_back(a | mb | FLT | PCW);
          ret = 0;
        end else if (op == OP_SW) tr.push_back(a | mb | PCW);
        else begin
          tr.push_back(a | mb);
          tr.push_back(a | RWR | PCW | M2R);
        end
      end else begin
        tr.push_back(a);
        tr.push_back(a | RWR | PCW | (op == OP_JAL ? BRB : 12'd0));
      end
    end
    for (int i = -dly; i < tr.size(); i++) begin
      @(negedge clk);
      reset = 1'b0;
      instr_valid = i == 0 ? 1'b1 : i < 0 ? 1'b0 : 1'($urandom);
      Opcode = i == 1 ? op : 7'($urandom);
      mem_ready = (mem && i >= 3) ? (i - 3 == w) : 1'($urandom);
      #1;
      want = 12'd0;
      if (i >= 0) want = tr[i];
      n_chk += 2;
      if (outs !== want) begin
        n_fail++;
        $display("FAIL %s op=%b cycle %0d outputs=%b expected=%b", name, op, i, outs, want);
      end
      if (retired !== exp_ret) begin
        n_fail++;
        $display("FAIL %s op=%b cycle %0d retired=%0d expected=%0d", name, op, i, retired, exp_ret);
      end
    end
    if (ret) exp_ret++;
  endtask
  task automatic apply_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = 1'b1;
      instr_valid = 1'($urandom);
      Opcode = 7'($urandom);
      mem_ready = 1'($urandom);
      #1;
      n_chk++;
      if (outs !== 12'd0) begin
        n_fail++;
        $display("FAIL reset outputs=%b expected=0", outs);
      end
      if (k > 0) begin
        n_chk++;
        if (retired !== '0) begin
          n_fail++;
          $display("FAIL reset retired=%0d expected=0", retired);
        end
      end
    end
    exp_ret = '0;
  endtask
  task automatic test_reset();
    apply_reset(3);
  endtask
  task automatic test_add();
    issue(OP_R, 0, 0, "add");
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_chk += 2;
    if (retired !== 2'd1) begin
      n_fail++;
      $display("FAIL add_retired retired=%0d expected=1", retired);
    end
    if (outs !== 12'd0) begin
      n_fail++;
      $display("FAIL add_idle outputs=%b expected=0", outs);
    end
  endtask
  task automatic test_memory();
    issue(OP_LW, 2, 1, "lw_wait2");
    issue(OP_SW, 0, 0, "sw_ready0");
    issue(OP_SW, 99, 0, "sw_timeout");
    issue(OP_LW, T, 0, "lw_ready_at_limit");
    issue(OP_SW, T, 2, "sw_ready_at_limit");
    issue(OP_LW, T + 1, 0, "lw_timeout");
    issue(OP_LW, 0, 0, "lw_after_timeout");
  endtask
  task automatic test_illegal_branch();
    issue(7'b1111111, 0, 0, "illegal");
    issue(OP_BR, 0, 0, "beq");
    issue(7'b0000000, 0, 1, "illegal_zero");
    issue(OP_JAL, 0, 0, "jal");
    issue(OP_LUI, 0, 0, "lui");
    issue(OP_I, 0, 0, "addi");
  endtask
  task automatic test_reset_mid_memory();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reset = 1'b0;
      instr_valid = i == 0;
      Opcode = i == 1 ? OP_LW : 7'($urandom);
      mem_ready = i >= 3 ? 1'b0 : 1'($urandom);
      #1;
    end
    n_chk++;
    if (MemRead !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mem_read MemRead=%b expected=1", MemRead);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_chk++;
    if (outs !== 12'd0) begin
      n_fail++;
      $display("FAIL mid_mem_reset outputs=%b expected=0", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_chk += 2;
    if (outs !== 12'd0) begin
      n_fail++;
      $display("FAIL mid_mem_after outputs=%b expected=0", outs);
    end
    if (retired !== '0) begin
      n_fail++;
      $display("FAIL mid_mem_retired retired=%0d expected=0", retired);
    end
    exp_ret = '0;
    issue(OP_R, 0, 0, "add_after_reset");
  endtask
  task automatic test_wrap();
    apply_reset(2);
    for (int k = 0; k < 4; k++) issue(OP_R, 0, 0, "wrap_add");
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_chk++;
    if (retired !== '0) begin
      n_fail++;
      $display("FAIL wrap retired=%0d expected=0", retired);
    end
  endtask
  task automatic test_back_to_back();
    logic [6:0] ops [7] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI};
    logic [6:0] op;
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 7) == 7 ? 7'($urandom) : ops[$urandom_range(0, 6)];
      issue(op, $urandom_range(0, T + 2), $urandom_range(0, 2), "random");
    end
  endtask
  initial begin
    exp_ret = '0;
    test_reset();
    test_add();
    test_memory();
    test_illegal_branch();
    test_reset_mid_memory();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
